// File: rtl/d20_roll_arbiter.sv
// -----------------------------------------------------------------------------
// d20_roll_arbiter
//
// Shares one d20 die and its two-digit display between two players. A roll
// button rising edge requests the die; the two players are arbitrated
// round-robin. The winner gets a timed "spin" animation on dicenum. The last
// animation step is the final 1..20 result, which is then added to that
// player's saturating score.
//
// Ports
//   clk            in   system clock, all state changes on posedge
//   reset          in   asynchronous, active-high reset
//   roll_req[1:0]  in   debounced roll buttons, bit i = player i
//   clear_scores   in   synchronous clear of both scores (wins over an add)
//   busy           out  a roll is in progress (state != IDLE)
//   grant[1:0]     out  one-hot owner of the die during SPIN/DONE
//   dicenum[4:0]   out  value for the seven-segment decoder, always 1..20
//   result_valid   out  one-cycle pulse while the final value is shown
//   result_player  out  player index of the current/last roll
//   score0/score1  out  running 9-bit scores, saturating at 511
//
// FSM states
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | die free; grant on the first cycle any candidate request exists
//   SPIN    | animation running; dicenum reloads from rng every TICK_DIV edges
//   DONE    | final value presented for one cycle; score updated on exit
// -----------------------------------------------------------------------------
module d20_roll_arbiter #(
  parameter int unsigned TICK_DIV   = 2_500_000,
  parameter int unsigned SPIN_TICKS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] roll_req,
  input  logic       clear_scores,
  output logic       busy,
  output logic [1:0] grant,
  output logic [4:0] dicenum,
  output logic       result_valid,
  output logic       result_player,
  output logic [8:0] score0,
  output logic [8:0] score1
);

  // Both timers are down-counters: the step edge is the one where the
  // counter reads zero, so they are loaded with (count - 1).
  localparam int unsigned TMR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STP_W = (SPIN_TICKS > 1) ? $clog2(SPIN_TICKS) : 1;

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TICK_DIV - 1);
  localparam logic [STP_W-1:0] STP_RELOAD = STP_W'(SPIN_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       rng_q, rng_d;
  logic [1:0]       req_prev_q;
  logic [1:0]       pend_q, pend_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic             player_q, player_d;
  logic [4:0]       dice_q, dice_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [STP_W-1:0] stp_q, stp_d;
  logic [8:0]       score0_q, score0_d;
  logic [8:0]       score1_q, score1_d;

  logic [1:0] rise;
  logic [1:0] cand;
  logic       win_valid;
  logic       win_idx;
  logic [1:0] win_oh;
  logic       tick;
  logic       last_step;
  logic       add_en;

  function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [4:0] b);
    logic [9:0] sum;
    sum = {1'b0, a} + {5'd0, b};
    return sum[9] ? 9'd511 : sum[8:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Free-running 1..20 counter; its pre-increment value is the sample taken
  // on each animation step, so the final result depends on button timing.
  // ---------------------------------------------------------------------------
  always_comb begin
    rng_d = (rng_q == 5'd20) ? 5'd1 : rng_q + 5'd1;
  end

  // ---------------------------------------------------------------------------
  // Request edge detect and round-robin pick
  // ---------------------------------------------------------------------------
  assign rise      = roll_req & ~req_prev_q;
  assign cand      = pend_q | rise;
  assign win_valid = |cand;
  // On a tie the player that did not win last time goes; otherwise the only
  // candidate wins (cand == 2'b10 -> 1, cand == 2'b01 -> 0).
  assign win_idx   = (cand == 2'b11) ? ~last_q : cand[1];
  assign win_oh    = win_idx ? 2'b10 : 2'b01;

  assign tick      = (tmr_q == '0);
  assign last_step = (stp_q == '0);

  // ---------------------------------------------------------------------------
  // FSM next state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    player_d = player_q;
    last_d   = last_q;
    dice_d   = dice_q;
    tmr_d    = tmr_q;
    stp_d    = stp_q;
    add_en   = 1'b0;
    // Edges from the current owner are dropped; grant_q is 00 in IDLE so
    // there every edge is latched.
    pend_d   = pend_q | (rise & ~grant_q);

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_SPIN;
          grant_d  = win_oh;
          player_d = win_idx;
          last_d   = win_idx;
          pend_d   = cand & ~win_oh;
          tmr_d    = TMR_RELOAD;
          stp_d    = STP_RELOAD;
        end
      end

      ST_SPIN: begin
        if (tick) begin
          dice_d = rng_q;
          tmr_d  = TMR_RELOAD;
          if (last_step) begin
            state_d = ST_DONE;
          end else begin
            stp_d = stp_q - STP_W'(1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_DONE: begin
        add_en  = 1'b1;
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scores: clear has priority over the DONE-exit add.
  // ---------------------------------------------------------------------------
  always_comb begin
    score0_d = score0_q;
    score1_d = score1_q;
    if (clear_scores) begin
      score0_d = 9'd0;
      score1_d = 9'd0;
    end else if (add_en) begin
      if (player_q) begin
        score1_d = sat_add(score1_q, dice_q);
      end else begin
        score0_d = sat_add(score0_q, dice_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rng_q      <= 5'd1;
      req_prev_q <= 2'b00;
      pend_q     <= 2'b00;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      player_q   <= 1'b0;
      dice_q     <= 5'd1;
      tmr_q      <= '0;
      stp_q      <= '0;
      score0_q   <= 9'd0;
      score1_q   <= 9'd0;
    end else begin
      state_q    <= state_d;
      rng_q      <= rng_d;
      req_prev_q <= roll_req;
      pend_q     <= pend_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      player_q   <= player_d;
      dice_q     <= dice_d;
      tmr_q      <= tmr_d;
      stp_q      <= stp_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded straight from registers)
  // ---------------------------------------------------------------------------
  assign busy          = (state_q != ST_IDLE);
  assign grant         = grant_q;
  assign dicenum       = dice_q;
  assign result_valid  = (state_q == ST_DONE);
  assign result_player = player_q;
  assign score0        = score0_q;
  assign score1        = score1_q;

endmodule
